// File: rtl/calc_op_sequencer.sv
// Command sequencer for the calculator's two-entry operand register file (X=0, Y=1).
// Build option: define CALC_SEQ_MUL_EN to implement MUL; otherwise MUL is rejected with err.
module calc_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             err,
  output logic             rf_write,
  output logic             rf_addr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [WIDTH-1:0] rf_rdata
);

  localparam logic [1:0] CMD_LOAD_X = 2'b00;
  localparam logic [1:0] CMD_LOAD_Y = 2'b01;
  localparam logic [1:0] CMD_EXEC   = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_MUL     = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_X, RD_Y, CALC, WB, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       cmd_reg, op_reg;
  logic [WIDTH-1:0] operand_reg, a_reg, b_reg, result_reg;
  logic             ovf_reg, err_reg;
  logic             write_state;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] calc_res;
  logic             calc_ovf, calc_err;

  assign sum_w = {1'b0, a_reg} + {1'b0, b_reg};

`ifdef CALC_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_w;
  assign prod_w = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
`endif

  always_comb begin
    calc_res = a_reg & b_reg;
    calc_ovf = 1'b0;
    calc_err = 1'b0;
    case (op_reg)
      OP_ADD: begin
        calc_res = sum_w[WIDTH-1:0];
        calc_ovf = sum_w[WIDTH];
      end
      OP_SUB: begin
        calc_res = a_reg - b_reg;
        calc_ovf = (a_reg < b_reg);
      end
      OP_MUL: begin
`ifdef CALC_SEQ_MUL_EN
        calc_res = prod_w[WIDTH-1:0];
        calc_ovf = |prod_w[2*WIDTH-1:WIDTH];
`else
        // Rejected: keep the previous result and flag untouched.
        calc_res = result_reg;
        calc_ovf = ovf_reg;
        calc_err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    write_state = 1'b0;
    rf_addr     = 1'b0;
    rf_wdata    = '0;
    case (state_reg)
      IDLE: if (start) state_next = (cmd == CMD_EXEC) ? RD_X : WR_A;
      WR_A: begin
        write_state = 1'b1;
        if (cmd_reg == CMD_CLEAR) begin
          state_next = WR_B;
        end else begin
          rf_addr    = (cmd_reg == CMD_LOAD_Y);
          rf_wdata   = operand_reg;
          state_next = DONE;
        end
      end
      WR_B: begin
        write_state = 1'b1;
        rf_addr     = 1'b1;
        state_next  = DONE;
      end
      RD_X: state_next = RD_Y;
      RD_Y: begin
        rf_addr    = 1'b1;
        state_next = CALC;
      end
`ifdef CALC_SEQ_MUL_EN
      CALC: state_next = WB;
`else
      CALC: state_next = (op_reg == OP_MUL) ? DONE : WB;
`endif
      WB: begin
        write_state = 1'b1;
        rf_wdata    = result_reg;
        state_next  = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset also masks the write strobe so an aborted command performs no further writes.
  assign rf_write = write_state & ~reset;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign result   = result_reg;
  assign ovf      = ovf_reg;
  assign err      = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cmd_reg     <= CMD_LOAD_X;
      op_reg      <= OP_ADD;
      operand_reg <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      ovf_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          cmd_reg     <= cmd;
          op_reg      <= op;
          operand_reg <= operand;
        end
        RD_X: a_reg <= rf_rdata;
        RD_Y: b_reg <= rf_rdata;
        CALC: begin
          result_reg <= calc_res;
          ovf_reg    <= calc_ovf;
          err_reg    <= calc_err;
        end
        WR_B: begin
          result_reg <= '0;
          ovf_reg    <= 1'b0;
          err_reg    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
